wrr_lock_arbiter: RTL and testbench

- Parametrised successor to the single-cycle round-robin arbiter.
- Adds per-client weighted credits, grant locking for multi-beat transactions (held until a `last` beat), and a run-time fixed-priority mode.
- Sits in front of shared resources (bus ports, memory banks) whose users issue multi-beat bursts.
- Search direction is unchanged: priority walks downward from the last owner and wraps to index CLIENTS-1.

---
 rtl/wrr_lock_arbiter_pkg.sv | 18 +
 rtl/wrr_lock_arbiter_rr_pick.sv | 39 +++
 rtl/wrr_lock_arbiter.sv | 139 +++++++++++++
 tb/tb_wrr_lock_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wrr_lock_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin lock arbiter.
package wrr_lock_arbiter_pkg;

    // Upper bound on the number of requesters this arbiter is built for.
    localparam int MAX_CLIENTS = 64;

    // IDLE: arbitrating; GRANT: an owner holds the resource until release.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Step a pointer one position downward, wrapping 0 -> n-1.
    function automatic int wrap_dec(input int idx, input int n);
        return (idx == 0) ? n - 1 : idx - 1;
    endfunction

endpackage

// File: rtl/wrr_lock_arbiter_rr_pick.sv
// Combinational downward round-robin picker.
// Search order: ptr, ptr-1, ..., 0, then CLIENTS-1, ..., ptr+1.
// Done as a masked search over bits <= ptr, falling back to the
// highest set bit of the whole vector when nothing is at or below ptr.
module rr_pick #(
    parameter int CLIENTS = 16,
    parameter int IDX_W   = $clog2(CLIENTS)
) (
    input  logic [CLIENTS-1:0] vec,
    input  logic [IDX_W-1:0]   ptr,
    output logic               vld,
    output logic [IDX_W-1:0]   idx
);

    logic             masked_vld;
    logic [IDX_W-1:0] masked_idx;
    logic [IDX_W-1:0] full_idx;

    // Highest set bit at or below ptr, and highest set bit overall.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        masked_vld = 1'b0;
        masked_idx = '0;
        full_idx   = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            if (vec[i]) begin
                full_idx = IDX_W'(i);
            end
            if (vec[i] && (i <= int'(ptr))) begin
                masked_vld = 1'b1;
                masked_idx = IDX_W'(i);
            end
        end
        vld = |vec;
        idx = masked_vld ? masked_idx : full_idx;
    end

endmodule

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with burst locking and a fixed-priority mode.
// A grant is held until the owner signals last (or drops req); each client
// may win w+1 consecutive bursts per turn, where w is its weight field.
module wrr_lock_arbiter
    import wrr_lock_arbiter_pkg::*;
#(
    parameter  int CLIENTS  = 16,
    parameter  int WEIGHT_W = 4,
    localparam int IDX_W    = $clog2(CLIENTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CLIENTS-1:0]          req,
    input  logic [CLIENTS-1:0]          last,
    input  logic [CLIENTS*WEIGHT_W-1:0] weight,
    input  logic                        mode,
    output logic [CLIENTS-1:0]          gnt,
    output logic                        gnt_vld,
    output logic [IDX_W-1:0]            gnt_id
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(CLIENTS - 1);

    state_t                state_q,   state_d;
    logic [IDX_W-1:0]      ptr_q,     ptr_d;
    logic [WEIGHT_W-1:0]   credit_q,  credit_d;
    logic [IDX_W-1:0]      prev_q,    prev_d;
    logic [CLIENTS-1:0]    gnt_q,     gnt_d;
    logic                  gnt_vld_q, gnt_vld_d;
    logic [IDX_W-1:0]      gnt_id_q,  gnt_id_d;

    logic [IDX_W-1:0]      pick_ptr;
    logic                  pick_vld;
    logic [IDX_W-1:0]      pick_idx;
    logic                  own_req;
    logic                  own_last;
    logic                  rel;

    // Fixed-priority mode is a round-robin search that always starts at the top.
    assign pick_ptr = mode ? TOP_IDX : ptr_q;

    rr_pick #(
        .CLIENTS (CLIENTS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .vec (req),
        .ptr (pick_ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    // Only the owner's req/last matter while a grant is held.
    assign own_req  = req[gnt_id_q];
    assign own_last = last[gnt_id_q];
    assign rel      = !own_req || own_last;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the
        // pre-edge value of the others, independent of statement order.
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= TOP_IDX;
            credit_q  <= '0;
            prev_q    <= TOP_IDX;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            credit_q  <= credit_d;
            prev_q    <= prev_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_id_q  <= gnt_id_d;
        end
    end

    // Next state: lock on a winner, return to IDLE on release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = GRANT;
            GRANT:   if (rel)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant outputs, credit and pointer bookkeeping.
    always_comb begin
        ptr_d     = ptr_q;
        credit_d  = credit_q;
        prev_d    = prev_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        gnt_id_d  = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gnt_vld_d       = 1'b1;
                    gnt_id_d        = pick_idx;
                    // A returning owner keeps its remaining credit for this turn.
                    if (pick_idx != prev_q) begin
                        credit_d = weight[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
                    end
                    prev_d = pick_idx;
                end
            end
            GRANT: begin
                if (rel) begin
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    gnt_id_d  = '0;
                    if (mode) begin
                        ptr_d = TOP_IDX;
                    end else if (credit_q != '0) begin
                        credit_d = credit_q - WEIGHT_W'(1);
                        ptr_d    = gnt_id_q;
                    end else begin
                        ptr_d = IDX_W'(wrap_dec(int'(gnt_id_q), CLIENTS));
                    end
                end
            end
            default: begin
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
                gnt_id_d  = '0;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_id  = gnt_id_q;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Self-checking bench for wrr_lock_arbiter (4 clients, 4-bit weights):
// directed vector table, hand-written burst sequences, then randomized
// traffic compared against a behavioural model.
module tb_wrr_lock_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic [N*WW-1:0] weight;
    logic          mode;
    logic [N-1:0]  gnt;
    logic          gnt_vld;
    logic [1:0]    gnt_id;

    int n_checks = 0;
    int n_fail   = 0;

    wrr_lock_arbiter #(.CLIENTS(N), .WEIGHT_W(WW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .last    (last),
        .weight  (weight),
        .mode    (mode),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic [N-1:0]  req;
        logic [N-1:0]  last;
        logic          mode;
        logic [N*WW-1:0] weight;
        logic [N-1:0]  exp_gnt;
        logic [1:0]    exp_id;
        string         name;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lt,
                                input logic m, input logic [N*WW-1:0] w,
                                input logic [N-1:0] eg, input logic [1:0] eid, input string nm);
        vec_t v;
        v.rst_n = r; v.req = rq; v.last = lt; v.mode = m; v.weight = w;
        v.exp_gnt = eg; v.exp_id = eid; v.name = nm;
        return v;
    endfunction

    // Drive one cycle of inputs, clock, then compare outputs one step after the edge.
    task automatic apply(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lt,
                         input logic m, input logic [N*WW-1:0] w,
                         input logic [N-1:0] eg, input logic [1:0] eid, input string nm);
        rst_n = r; req = rq; last = lt; mode = m; weight = w;
        @(posedge clk);
        #1;
        check({nm, " gnt"},     32'(gnt),     32'(eg));
        check({nm, " gnt_vld"}, 32'(gnt_vld), 32'(|eg));
        check({nm, " gnt_id"},  32'(gnt_id),  32'(eid));
    endtask

    // Behavioural model: owner of -1 means idle.
    int m_owner, m_ptr, m_credit, m_prev;

    task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lt,
                              input logic m, input logic [N*WW-1:0] w);
        int start;
        int win;
        if (!r) begin
            m_owner = -1; m_ptr = N - 1; m_credit = 0; m_prev = N - 1;
        end else if (m_owner < 0) begin
            if (rq != '0) begin
                start = m ? N - 1 : m_ptr;
                win = -1;
                // Walk downward from start, wrapping, first requester wins.
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && rq[(start - k + N) % N]) win = (start - k + N) % N;
                end
                if (win != m_prev) m_credit = int'(w[win*WW +: WW]);
                m_prev  = win;
                m_owner = win;
            end
        end else if (!rq[m_owner] || lt[m_owner]) begin
            if (m) begin
                m_ptr = N - 1;
            end else if (m_credit > 0) begin
                m_credit--;
                m_ptr = m_owner;
            end else begin
                m_ptr = (m_owner + N - 1) % N;
            end
            m_owner = -1;
        end
    endtask

    task automatic rnd_cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lt,
                             input logic m, input logic [N*WW-1:0] w);
        logic [N-1:0] eg;
        logic [1:0]   eid;
        model_step(r, rq, lt, m, w);
        eg  = (m_owner < 0) ? '0 : N'(1 << m_owner);
        eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        apply(r, rq, lt, m, w, eg, eid, "rand");
    endtask

    initial begin
        logic [N-1:0]    r_req;
        logic [N-1:0]    r_last;
        logic            r_mode;
        logic [N*WW-1:0] r_w;
        logic            r_rst;

        rst_n = 1'b0; req = '0; last = '0; mode = 1'b0; weight = '0;

        // All weights 0, single-beat bursts: 3,2,1,0,3 every other cycle.
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, 2'd0, "rr reset"));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 16'h0000, 4'b1000, 2'd3, "rr g3"));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 16'h0000, 4'b0000, 2'd0, "rr bub"));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 16'h0000, 4'b0100, 2'd2, "rr g2"));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 16'h0000, 4'b0000, 2'd0, "rr bub"));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 16'h0000, 4'b0010, 2'd1, "rr g1"));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 16'h0000, 4'b0000, 2'd0, "rr bub"));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 16'h0000, 4'b0001, 2'd0, "rr g0"));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 16'h0000, 4'b0000, 2'd0, "rr bub"));
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 16'h0000, 4'b1000, 2'd3, "rr wrap g3"));
        // weight[2]=2: order 2,2,2,1,2,2,2,1.
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 16'h0200, 4'b0000, 2'd0, "wt reset"));
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < 3; b++) begin
                tbl.push_back(mk(1, 4'b0110, 4'b1111, 0, 16'h0200, 4'b0100, 2'd2, "wt g2"));
                tbl.push_back(mk(1, 4'b0110, 4'b1111, 0, 16'h0200, 4'b0000, 2'd0, "wt bub"));
            end
            tbl.push_back(mk(1, 4'b0110, 4'b1111, 0, 16'h0200, 4'b0010, 2'd1, "wt g1"));
            tbl.push_back(mk(1, 4'b0110, 4'b1111, 0, 16'h0200, 4'b0000, 2'd0, "wt bub"));
        end
        // Fixed priority always picks 2; clearing mode during the grant gives 0 then 2.
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 16'h0000, 4'b0000, 2'd0, "fp reset"));
        tbl.push_back(mk(1, 4'b0101, 4'b1111, 1, 16'h0000, 4'b0100, 2'd2, "fp g2"));
        tbl.push_back(mk(1, 4'b0101, 4'b1111, 1, 16'h0000, 4'b0000, 2'd0, "fp bub"));
        tbl.push_back(mk(1, 4'b0101, 4'b1111, 1, 16'h0000, 4'b0100, 2'd2, "fp g2 again"));
        tbl.push_back(mk(1, 4'b0101, 4'b1111, 0, 16'h0000, 4'b0000, 2'd0, "fp clear"));
        tbl.push_back(mk(1, 4'b0101, 4'b1111, 0, 16'h0000, 4'b0001, 2'd0, "fp then g0"));
        tbl.push_back(mk(1, 4'b0101, 4'b1111, 0, 16'h0000, 4'b0000, 2'd0, "fp bub"));
        tbl.push_back(mk(1, 4'b0101, 4'b1111, 0, 16'h0000, 4'b0100, 2'd2, "fp then g2"));

        foreach (tbl[i]) begin
            apply(tbl[i].rst_n, tbl[i].req, tbl[i].last, tbl[i].mode, tbl[i].weight,
                  tbl[i].exp_gnt, tbl[i].exp_id, tbl[i].name);
        end

        // Client 1 four-beat burst; client 3 requests from beat 2 and waits.
        apply(0, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, 2'd0, "burst reset");
        apply(1, 4'b0010, 4'b0000, 0, 16'h0000, 4'b0010, 2'd1, "burst beat1");
        apply(1, 4'b0010, 4'b0000, 0, 16'h0000, 4'b0010, 2'd1, "burst beat2");
        apply(1, 4'b1010, 4'b1000, 0, 16'h0000, 4'b0010, 2'd1, "burst beat3");
        apply(1, 4'b1010, 4'b1000, 0, 16'h0000, 4'b0010, 2'd1, "burst beat4");
        apply(1, 4'b1010, 4'b0010, 0, 16'h0000, 4'b0000, 2'd0, "burst release");
        apply(1, 4'b1000, 4'b0000, 0, 16'h0000, 4'b1000, 2'd3, "burst next g3");

        // Owner abort mid-burst, then reset while a grant is held.
        apply(0, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, 2'd0, "abort reset");
        apply(1, 4'b1111, 4'b0000, 0, 16'h0000, 4'b1000, 2'd3, "abort g3");
        apply(1, 4'b1111, 4'b0000, 0, 16'h0000, 4'b1000, 2'd3, "abort hold");
        apply(1, 4'b0111, 4'b0000, 0, 16'h0000, 4'b0000, 2'd0, "abort drop");
        apply(1, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0100, 2'd2, "abort next g2");
        apply(0, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0000, 2'd0, "midburst reset");
        apply(1, 4'b1111, 4'b0000, 0, 16'h0000, 4'b1000, 2'd3, "post reset g3");

        // Randomized traffic against the model.
        r_req = '0; r_last = '0; r_mode = 1'b0; r_w = '0;
        rnd_cycle(1'b0, r_req, r_last, r_mode, r_w);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) r_req = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) r_last[i] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) r_mode = ~r_mode;
            if ($urandom_range(0, 39) == 0) begin
                for (int i = 0; i < N; i++) r_w[i*WW +: WW] = WW'($urandom_range(0, 3));
            end
            r_rst = ($urandom_range(0, 199) != 0);
            rnd_cycle(r_rst, r_req, r_last, r_mode, r_w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
